// File: rtl/dmem_responder.sv
// Wait-stated data memory responder for a single-cycle/multi-cycle datapath: IDLE -> WAIT -> RESP.
// Define DMEM_BYTE_ACCESS_EN to enable STRB/LDRB byte-lane accesses; otherwise every access is a word access.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic        ByteOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic        byte_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accWrite;
  logic             accByte;
  logic             accByteMode;
  logic [31:0]      accAddr;
  logic [31:0]      accWdata;
  logic [29:0]      accWordOff;
  logic [IDX_W-1:0] accIdx;
  logic             accErr;
  logic [31:0]      wordRd;
  logic [7:0]       laneByte;
  logic [31:0]      loadData_d;
  logic             goResp;

`ifdef DMEM_BYTE_ACCESS_EN
  assign accByteMode = accByte;
`else
  logic unusedByte;
  assign accByteMode = 1'b0;
  assign unusedByte  = accByte;
`endif

  // With zero wait states the access completes on the accepting edge, so use the live inputs then.
  always_comb begin
    accWrite = MemWrite;
    accByte  = ByteOp;
    accAddr  = Addr;
    accWdata = WriteData;
    if (state_q != IDLE) begin
      accWrite = write_q;
      accByte  = byte_q;
      accAddr  = addr_q;
      accWdata = wdata_q;
    end
    accWordOff = accAddr[31:2] - BASE_ADDR[31:2];
    accIdx     = accWordOff[IDX_W-1:0];
    accErr     = (accAddr < BASE_ADDR) ||
                 ({2'b00, accWordOff} >= DEPTH_WORDS) ||
                 (!accByteMode && (accAddr[1:0] != 2'b00));
    wordRd     = mem_q[accIdx];
    laneByte   = wordRd[{accAddr[1:0], 3'b000} +: 8];
    loadData_d = accByteMode ? {24'h0, laneByte} : wordRd;
    goResp     = 1'b0;
    case (state_q)
      IDLE:    goResp = MemReq && (WAIT_CYCLES == 0);
      WAIT:    goResp = (cnt_q == 4'd1);
      default: goResp = 1'b0;
    endcase
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && goResp && accWrite && !accErr) begin
      if (accByteMode) mem_q[accIdx][{accAddr[1:0], 3'b000} +: 8] <= accWdata[7:0];
      else             mem_q[accIdx] <= accWdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemReq) begin
            write_q <= MemWrite;
            byte_q  <= ByteOp;
            addr_q  <= Addr;
            wdata_q <= WriteData;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (goResp) begin
        ready_q <= 1'b1;
        err_q   <= accErr;
        if (!accWrite) rdata_q <= accErr ? 32'h0 : loadData_d;
      end
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, randomized traffic against a word-array model,
// plus held-request and reset-during-wait sequences on a 2-wait and a 0-wait instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DMEM_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        rst   [2];
  logic        req   [2];
  logic        wr    [2];
  logic        bop   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int          waitC  [2] = '{2, 0};
  int unsigned depthW [2] = '{64, 16};
  logic [31:0] baseA  [2] = '{32'h0, 32'h100};

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(rst[0]), .MemReq(req[0]), .MemWrite(wr[0]), .ByteOp(bop[0]),
    .Addr(addr[0]), .WriteData(wdata[0]), .ReadData(rdata[0]), .MemReady(ready[0]), .MemErr(err[0]));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk(clk), .reset(rst[1]), .MemReq(req[1]), .MemWrite(wr[1]), .ByteOp(bop[1]),
    .Addr(addr[1]), .WriteData(wdata[1]), .ReadData(rdata[1]), .MemReady(ready[1]), .MemErr(err[1]));

  int checks = 0;
  int errors = 0;

  logic [31:0] tbMem  [2][64];
  logic [31:0] rdModel[2];

  typedef struct {
    int          unit;
    bit          w;
    bit          b;
    logic [31:0] a;
    logic [31:0] d;
    bit          expErr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(int u, bit w, bit b, logic [31:0] a, logic [31:0] d, bit e, logic [31:0] x);
    vec_t v;
    v.unit = u; v.w = w; v.b = b; v.a = a; v.d = d; v.expErr = e; v.expData = x;
    vecs.push_back(v);
  endfunction

  // Reference: memory is an array of words, errors follow the range/alignment rules directly.
  function automatic void modelAccess(input int u, input bit w, input bit b, input logic [31:0] a,
                                      input logic [31:0] d, output bit e, output logic [31:0] rd);
    logic [31:0] off;
    logic [31:0] idx;
    bit          byteMode;
    byteMode = BYTE_EN && b;
    off = a - baseA[u];
    idx = off / 4;
    e = (a < baseA[u]) || (idx >= depthW[u]) || (!byteMode && (a % 4 != 0));
    if (w) begin
      if (!e) begin
        if (byteMode) tbMem[u][idx][8*int'(a % 4) +: 8] = d[7:0];
        else          tbMem[u][idx] = d;
      end
    end else if (e) begin
      rdModel[u] = 32'h0;
    end else if (byteMode) begin
      rdModel[u] = {24'h0, tbMem[u][idx][8*int'(a % 4) +: 8]};
    end else begin
      rdModel[u] = tbMem[u][idx];
    end
    rd = rdModel[u];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the idle cycle after RESP.
  task automatic applyStimulus(input int u, input bit w, input bit b, input logic [31:0] a,
                               input logic [31:0] d, input bit expErr, input logic [31:0] expData,
                               input string tag);
    wr[u] = w; bop[u] = b; addr[u] = a; wdata[u] = d; req[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[u] = 1'b0;
    for (int c = 0; c < waitC[u]; c++) begin
      checkOutput({tag, "_wait"}, {30'h0, ready[u], err[u]}, 32'h0);
      @(negedge clk);
    end
    checkOutput({tag, "_ready"}, {31'h0, ready[u]}, 32'h1);
    checkOutput({tag, "_err"}, {31'h0, err[u]}, {31'h0, expErr});
    checkOutput({tag, "_data"}, rdata[u], expData);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {30'h0, ready[u], err[u]}, 32'h0);
    checkOutput({tag, "_hold"}, rdata[u], expData);
  endtask

  // MemReq held high: responses must recur every WAIT_CYCLES+2 cycles.
  task automatic heldReq(input int u, input logic [31:0] a);
    bit          e;
    logic [31:0] x;
    int          p;
    p = waitC[u] + 2;
    modelAccess(u, 1'b0, 1'b0, a, 32'h0, e, x);
    wr[u] = 1'b0; bop[u] = 1'b0; addr[u] = a; req[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3 * p; i++) begin
      checkOutput($sformatf("held%0d_rdy%0d", u, i), {31'h0, ready[u]}, {31'h0, (i % p) == waitC[u]});
      if ((i % p) == waitC[u]) checkOutput($sformatf("held%0d_data%0d", u, i), rdata[u], x);
      if (i < 3 * p - 1) @(negedge clk);
    end
    req[u] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("held%0d_after", u), {30'h0, ready[u], err[u]}, 32'h0);
  endtask

  initial begin
    bit          e;
    logic [31:0] x;
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    bit          b;
    logic [31:0] prior;

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req[u] = 1'b0; wr[u] = 1'b0; bop[u] = 1'b0;
      addr[u] = 32'h0; wdata[u] = 32'h0; rdModel[u] = 32'h0;
      for (int i = 0; i < 64; i++) tbMem[u][i] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset%0d_flags", u), {30'h0, ready[u], err[u]}, 32'h0);
      checkOutput($sformatf("reset%0d_data", u), rdata[u], 32'h0);
      rst[u] = 1'b0;
    end

    addVec(0, 1, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0);
    addVec(0, 0, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF);
    addVec(0, 0, 0, 32'h100, 32'h0,        1, 32'h0);
    addVec(0, 1, 0, 32'h14,  32'h11111111, 0, 32'h0);
    addVec(0, 1, 0, 32'h16,  32'h55555555, 1, 32'h0);
    addVec(0, 1, 0, 32'h102, 32'h99,       1, 32'h0);
    addVec(0, 0, 0, 32'h14,  32'h0,        0, 32'h11111111);
    addVec(0, 1, 0, 32'hFC,  32'hCAFEF00D, 0, 32'h11111111);
    addVec(0, 0, 0, 32'hFC,  32'h0,        0, 32'hCAFEF00D);
    addVec(0, 0, 0, 32'h13,  32'h0,        1, 32'h0);
    addVec(0, 1, 0, 32'h30,  32'h11223344, 0, 32'h0);
`ifdef DMEM_BYTE_ACCESS_EN
    addVec(0, 1, 1, 32'h31,  32'h000000AA, 0, 32'h0);
    addVec(0, 0, 0, 32'h30,  32'h0,        0, 32'h1122AA44);
    addVec(0, 0, 1, 32'h32,  32'h0,        0, 32'h00000022);
`else
    addVec(0, 1, 1, 32'h31,  32'h000000AA, 1, 32'h0);
    addVec(0, 0, 0, 32'h30,  32'h0,        0, 32'h11223344);
    addVec(0, 0, 1, 32'h32,  32'h0,        1, 32'h0);
`endif
    addVec(1, 0, 0, 32'h80,       32'h0,        1, 32'h0);
    addVec(1, 1, 0, 32'h100,      32'hA5A5A5A5, 0, 32'h0);
    addVec(1, 1, 0, 32'h13C,      32'h0F0F0F0F, 0, 32'h0);
    addVec(1, 0, 0, 32'h13C,      32'h0,        0, 32'h0F0F0F0F);
    addVec(1, 0, 0, 32'h140,      32'h0,        1, 32'h0);
    addVec(1, 0, 0, 32'h100,      32'h0,        0, 32'hA5A5A5A5);
    addVec(1, 1, 0, 32'hFFFFFFFC, 32'h77,       1, 32'hA5A5A5A5);

    foreach (vecs[i]) begin
      modelAccess(vecs[i].unit, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, e, x);
      applyStimulus(vecs[i].unit, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d,
                    vecs[i].expErr, vecs[i].expData, $sformatf("vec%0d", i));
    end

    // Give every word a known value so random loads have a defined expectation.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < int'(depthW[u]); i++) begin
        a = baseA[u] + 32'(4 * i);
        d = $urandom;
        modelAccess(u, 1'b1, 1'b0, a, d, e, x);
        applyStimulus(u, 1'b1, 1'b0, a, d, e, x, $sformatf("init%0d_%0d", u, i));
      end
    end

    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 80; n++) begin
        w = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        a = baseA[u] - 32'd8 + 32'($urandom_range(0, depthW[u] * 4 + 16));
        d = $urandom;
        modelAccess(u, w, b, a, d, e, x);
        applyStimulus(u, w, b, a, d, e, x, $sformatf("rnd%0d_%0d", u, n));
      end
    end

    heldReq(1, 32'h104);
    heldReq(0, 32'h20);

    // Reset while a store waits: the store must vanish and outputs must clear.
    prior = tbMem[0][8];
    wr[0] = 1'b1; bop[0] = 1'b0; addr[0] = 32'h20; wdata[0] = 32'h12345678; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checkOutput("rstwait_data", rdata[0], 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rstwait_flags%0d", i), {30'h0, ready[0], err[0]}, 32'h0);
      @(negedge clk);
    end
    rdModel[0] = 32'h0;
    modelAccess(0, 1'b0, 1'b0, 32'h20, 32'h0, e, x);
    checkOutput("rstwait_model", x, prior);
    applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, e, x, "rstwait_readback");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0, word-aligned.
REQ-004 SHALL have port clk  input  1: single clock, rising-edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port MemReq  input  1: request strobe from the processor datapath.
REQ-007 SHALL have port MemWrite  input  1: 1 = store, 0 = load; sampled with MemReq.
REQ-008 SHALL have port ByteOp  input  1: 1 = byte access (STRB/LDRB); sampled with MemReq.
REQ-009 SHALL have port Addr  input  32: byte address (ALUResult).
REQ-010 SHALL have port WriteData  input  32: store data.
REQ-011 SHALL have port ReadData  output  32: registered load data.
REQ-012 SHALL have port MemReady  output  1: one-cycle response strobe.
REQ-013 SHALL have port MemErr  output  1: error flag, valid only while MemReady=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; the reset state is IDLE.
REQ-015 IDLE: MemReq=1 at a rising edge SHALL latch MemWrite, ByteOp, Addr and WriteData, and load the wait counter with WAIT_CYCLES; next state is WAIT, or RESP if WAIT_CYCLES=0.
REQ-016 WAIT: the counter SHALL decrement each edge; at the edge where it equals 1, next state is RESP.
REQ-017 For a request accepted at edge k, MemReady SHALL be 1 exactly during the cycle after edge k+WAIT_CYCLES, for one cycle.
REQ-018 RESP: the next state SHALL be IDLE unconditionally; a new request is accepted no earlier than the edge ending RESP+1 (one idle cycle minimum).
REQ-019 MemReq in WAIT or RESP SHALL be ignored; no queuing.
REQ-020 Word index SHALL be (latched Addr - BASE_ADDR)>>2.
REQ-021 Out-of-range conditions SHALL be Addr < BASE_ADDR or index >= DEPTH_WORDS; either one raises MemErr in RESP.
REQ-022 Stores SHALL commit to the array on the edge entering RESP, only if MemErr would be 0.
REQ-023 Loads SHALL update ReadData on the edge entering RESP: word data, or 32'h0 on error.
REQ-024 Store responses SHALL leave ReadData unchanged.
REQ-025 ReadData SHALL hold its value between responses.
REQ-026 Word access (ByteOp=0 or macro absent) with latched Addr[1:0]!=0 SHALL set MemErr and suppress the store.
REQ-027 MemReady and MemErr SHALL be 0 in IDLE and WAIT.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, counter=0, MemReady=0, MemErr=0, ReadData=32'h0.
REQ-029 reset during WAIT SHALL discard the pending access; no store commits and no MemReady is produced.
REQ-030 Reset SHALL NOT clear array contents.
REQ-031 reset SHALL take priority over MemReq in the same cycle.

Configuration
REQ-032 Macro DMEM_BYTE_ACCESS_EN defined: ByteOp=1 store SHALL write WriteData[7:0] to byte lane Addr[1:0] only; ByteOp=1 load SHALL return the zero-extended byte of lane Addr[1:0]; byte accesses are never misaligned.
REQ-033 Macro DMEM_BYTE_ACCESS_EN undefined: ByteOp SHALL be ignored, all accesses are word accesses, and REQ-026 applies.

Verification
REQ-034 WAIT_CYCLES=2: store 32'hDEADBEEF @Addr 0x10 accepted at edge k -> MemReady=1, MemErr=0 only in cycle after edge k+2; then load 0x10 -> ReadData=32'hDEADBEEF.
REQ-035 WAIT_CYCLES=0: load accepted at edge k -> MemReady in cycle after edge k; MemReq held high continuously -> next acceptance only after the one idle cycle.
REQ-036 Load Addr 0x100 with DEPTH_WORDS=64 -> MemErr=1, ReadData=0; store to 0x102 -> MemErr=1, target word unchanged on readback.
REQ-037 reset asserted during WAIT of store 32'h12345678 @0x20 -> no MemReady, outputs 0, word 0x20 keeps its prior value.
REQ-038 With DMEM_BYTE_ACCESS_EN: word 0x30=32'h11223344, STRB 8'hAA @0x31 -> word reads 32'h1122AA44; LDRB @0x32 -> 32'h00000022.
